// File: rtl/seg7_readback_checker.sv
// Reads the calculator's four seven-segment digits back through one shared decoder
// and checks A + B against the displayed {carry, sum}, keeping saturating counters.
module seg7_readback_checker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [6:0]       hex0_i,
  input  logic [6:0]       hex1_i,
  input  logic [6:0]       hex2_i,
  input  logic [6:0]       hex3_i,
  input  logic             start_i,
  input  logic             clr_cnt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       value_a_o,
  output logic [3:0]       value_b_o,
  output logic [3:0]       sum_o,
  output logic             cout_o,
  output logic [3:0]       err_mask_o,
  output logic             pattern_err_o,
  output logic             match_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o
);

  typedef enum logic [1:0] {IDLE, SCAN, CHECK} state_t;

  state_t           state_q;
  logic [6:0]       snap_q [4];
  logic [1:0]       idx_q;
  logic [3:0]       a_s_q, b_s_q, s_s_q;
  logic             c_s_q;
  logic [3:0]       bad_q;

  logic             busy_q, done_q, cout_q, perr_q, match_q;
  logic [3:0]       value_a_q, value_b_q, sum_q, err_mask_q;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;

  logic [6:0]       seg_sel;
  logic [3:0]       dec_val;
  logic             dec_bad;
  logic [4:0]       sum5;
  logic             chk_match;

  // Shared decoder: the digit under the scan index is the only one decoded per cycle.
  always_comb begin
    seg_sel = snap_q[idx_q];
    dec_val = '0;
    dec_bad = 1'b0;
    case (seg_sel)
      7'b1000000: dec_val = 4'h0;
      7'b1111001: dec_val = 4'h1;
      7'b0100100: dec_val = 4'h2;
      7'b0110000: dec_val = 4'h3;
      7'b0011001: dec_val = 4'h4;
      7'b0010010: dec_val = 4'h5;
      7'b0000010: dec_val = 4'h6;
      7'b1111000: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0010000: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b0000011: dec_val = 4'hB;
      7'b1000110: dec_val = 4'hC;
      7'b0100001: dec_val = 4'hD;
      7'b0000110: dec_val = 4'hE;
      7'b0001110: dec_val = 4'hF;
      default:    dec_bad = 1'b1;
    endcase
    // The carry digit may only show 0 or 1.
    if (idx_q == 2'd3 && dec_val > 4'd1) begin
      dec_bad = 1'b1;
      dec_val = '0;
    end
  end

  always_comb begin
    sum5      = {1'b0, a_s_q} + {1'b0, b_s_q};
    chk_match = (sum5 == {c_s_q, s_s_q}) && (bad_q == 4'b0000);
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (state_q == CHECK) begin
      if (chk_match) begin
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end else begin
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end
    end
    if (clr_cnt_i) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      for (int unsigned i = 0; i < 4; i++) snap_q[i] <= '0;
      idx_q      <= '0;
      a_s_q      <= '0;
      b_s_q      <= '0;
      s_s_q      <= '0;
      c_s_q      <= 1'b0;
      bad_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      value_a_q  <= '0;
      value_b_q  <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      err_mask_q <= '0;
      perr_q     <= 1'b0;
      match_q    <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      done_q     <= 1'b0;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            snap_q[0] <= hex0_i;
            snap_q[1] <= hex1_i;
            snap_q[2] <= hex2_i;
            snap_q[3] <= hex3_i;
            idx_q     <= '0;
            bad_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          bad_q[idx_q] <= dec_bad;
          case (idx_q)
            2'd0:    a_s_q <= dec_val;
            2'd1:    b_s_q <= dec_val;
            2'd2:    s_s_q <= dec_val;
            default: c_s_q <= dec_val[0];
          endcase
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= CHECK;
        end
        CHECK: begin
          value_a_q  <= a_s_q;
          value_b_q  <= b_s_q;
          sum_q      <= s_s_q;
          cout_q     <= c_s_q;
          err_mask_q <= bad_q;
          perr_q     <= |bad_q;
          match_q    <= chk_match;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign value_a_o     = value_a_q;
  assign value_b_o     = value_b_q;
  assign sum_o         = sum_q;
  assign cout_o        = cout_q;
  assign err_mask_o    = err_mask_q;
  assign pattern_err_o = perr_q;
  assign match_o       = match_q;
  assign pass_cnt_o    = pass_cnt_q;
  assign fail_cnt_o    = fail_cnt_q;

endmodule

// File: tb/tb_seg7_readback_checker.sv
// Bench for seg7_readback_checker: table of plan and random vectors checked against
// a lookup-table model, plus hand sequences for snapshot, reset, hold-START and counter clear.
module tb_seg7_readback_checker;
  localparam int unsigned W = 2;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, clr_cnt;
  logic [6:0]   h0, h1, h2, h3;
  logic         busy, done, cout, perr, match;
  logic [3:0]   va, vb, sum, emask;
  logic [W-1:0] pcnt, fcnt;

  seg7_readback_checker #(.CNT_W(W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .hex0_i(h0), .hex1_i(h1), .hex2_i(h2), .hex3_i(h3),
    .start_i(start), .clr_cnt_i(clr_cnt),
    .busy_o(busy), .done_o(done),
    .value_a_o(va), .value_b_o(vb), .sum_o(sum), .cout_o(cout),
    .err_mask_o(emask), .pattern_err_o(perr), .match_o(match),
    .pass_cnt_o(pcnt), .fail_cnt_o(fcnt)
  );

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    logic [6:0] h0, h1, h2, h3;
    int a, b, s, c, err, m;
  } vec_t;

  vec_t vecs[$];
  int tests = 0, fails = 0;
  int mpass = 0, mfail = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lookup(input logic [6:0] seg);
    for (int i = 0; i < 16; i++) if (seg_tbl[i] == seg) return i;
    return -1;
  endfunction

  function automatic vec_t model(input logic [6:0] x0, x1, x2, x3);
    vec_t v;
    int d [4];
    v.h0 = x0; v.h1 = x1; v.h2 = x2; v.h3 = x3;
    d[0] = lookup(x0); d[1] = lookup(x1); d[2] = lookup(x2); d[3] = lookup(x3);
    if (d[3] > 1) d[3] = -1;
    v.err = 0;
    for (int i = 0; i < 4; i++) if (d[i] < 0) begin v.err += (1 << i); d[i] = 0; end
    v.a = d[0]; v.b = d[1]; v.s = d[2]; v.c = d[3];
    v.m = (v.err == 0 && v.a + v.b == v.c * 16 + v.s) ? 1 : 0;
    return v;
  endfunction

  function automatic vec_t mk(input logic [6:0] x0, x1, x2, x3,
                              input int a, b, s, c, err, m);
    vec_t v;
    v.h0 = x0; v.h1 = x1; v.h2 = x2; v.h3 = x3;
    v.a = a; v.b = b; v.s = s; v.c = c; v.err = err; v.m = m;
    return v;
  endfunction

  function automatic logic [6:0] rnd_digit();
    if ($urandom_range(0, 7) == 0) return 7'($urandom());
    return seg_tbl[$urandom_range(0, 15)];
  endfunction

  task automatic model_count(input int m);
    if (m != 0) begin if (mpass < CMAX) mpass++; end
    else begin if (mfail < CMAX) mfail++; end
  endtask

  task automatic cmp_results(input string tag, input vec_t v);
    check({tag, ".a"}, va, v.a);
    check({tag, ".b"}, vb, v.b);
    check({tag, ".sum"}, sum, v.s);
    check({tag, ".cout"}, cout, v.c);
    check({tag, ".err_mask"}, emask, v.err);
    check({tag, ".pattern_err"}, perr, (v.err != 0) ? 1 : 0);
    check({tag, ".match"}, match, v.m);
    check({tag, ".pass_cnt"}, pcnt, mpass);
    check({tag, ".fail_cnt"}, fcnt, mfail);
  endtask

  // Caller is positioned at a negedge; returns at the negedge where DONE is seen.
  task automatic run_check(input string tag, input vec_t v);
    int lat;
    h0 = v.h0; h1 = v.h1; h2 = v.h2; h3 = v.h3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, busy, 1);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
    check({tag, ".latency"}, lat, 5);
    check({tag, ".busy_after"}, busy, 0);
    model_count(v.m);
    cmp_results(tag, v);
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    mpass = 0; mfail = 0;
  endtask

  vec_t v1;
  int ndone, first_k, second_k;

  initial begin
    rst_n = 1'b0; start = 1'b0; clr_cnt = 1'b0;
    h0 = '1; h1 = '1; h2 = '1; h3 = '1;
    repeat (2) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.match", match, 0);
    check("rst.pass", pcnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    v1 = mk(7'b0110000, 7'b0100100, 7'b0010010, 7'b1000000, 3, 2, 5, 0, 0, 1);
    vecs.push_back(v1);
    vecs.push_back(mk(7'b0001110, 7'b0001110, 7'b0000110, 7'b1111001, 15, 15, 14, 1, 0, 1));
    vecs.push_back(mk(7'b0001110, 7'b0001110, 7'b1000000, 7'b1111001, 15, 15, 0, 1, 0, 0));
    vecs.push_back(mk(7'b0110000, 7'b0100100, 7'b1111111, 7'b1000000, 3, 2, 0, 0, 4, 0));
    vecs.push_back(mk(7'b0110000, 7'b0100100, 7'b0010010, 7'b0100100, 3, 2, 5, 0, 8, 0));
    for (int i = 0; i < 40; i++) begin
      logic [6:0] x0, x1, x2, x3;
      int a, b;
      x0 = rnd_digit(); x1 = rnd_digit();
      a = lookup(x0); b = lookup(x1);
      if (a >= 0 && b >= 0 && $urandom_range(0, 1) == 1) begin
        x2 = seg_tbl[(a + b) % 16];
        x3 = seg_tbl[(a + b) / 16];
      end else begin
        x2 = rnd_digit();
        x3 = ($urandom_range(0, 3) == 0) ? rnd_digit() : seg_tbl[$urandom_range(0, 1)];
      end
      vecs.push_back(model(x0, x1, x2, x3));
    end

    foreach (vecs[i]) run_check($sformatf("vec%0d", i), vecs[i]);

    clear_counters();
    for (int i = 0; i < 5; i++) run_check($sformatf("sat%0d", i), v1);
    check("sat.pass_final", pcnt, 3);

    // Snapshot immunity: HEX change and second START while busy.
    h0 = v1.h0; h1 = v1.h1; h2 = v1.h2; h3 = v1.h3;
    start = 1'b1;
    ndone = 0; first_k = -1;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin ndone++; if (first_k < 0) first_k = k; end
      if (k == 0) begin start = 1'b0; h0 = 7'b1111111; h1 = 7'b0000000; h2 = 7'b0100100; h3 = 7'b0010010; end
      if (k == 1) start = 1'b1;
      if (k == 2) start = 1'b0;
      if (k == 5) begin model_count(v1.m); cmp_results("snap", v1); end
    end
    check("snap.ndone", ndone, 1);
    check("snap.done_k", first_k, 5);

    // START held high: one check every 6 cycles.
    h0 = v1.h0; h1 = v1.h1; h2 = v1.h2; h3 = v1.h3;
    start = 1'b1;
    ndone = 0; first_k = -1; second_k = -1;
    for (int k = 0; k <= 11; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_k < 0) first_k = k; else second_k = k;
        model_count(v1.m);
      end
    end
    start = 1'b0;
    check("hold.ndone", ndone, 2);
    check("hold.first", first_k, 5);
    check("hold.second", second_k, 11);
    check("hold.pass", pcnt, mpass);
    repeat (6) @(negedge clk);

    // CLR_CNT coinciding with the DONE edge.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("clr.done", done, 1);
    check("clr.pass", pcnt, 0);
    check("clr.fail", fcnt, 0);
    mpass = 0; mfail = 0;
    run_check("after_clr", vecs[2]);

    // Reset during SCAN abandons the check.
    h0 = v1.h0; h1 = v1.h1; h2 = v1.h2; h3 = v1.h3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mpass = 0; mfail = 0;
    cmp_results("midrst", mk('0, '0, '0, '0, 0, 0, 0, 0, 0, 0));
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst.ndone", ndone, 0);
    check("midrst.busy_after", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/seg7_readback_checker.md
# seg7_readback_checker

- Sequential self-check block for the tiny calculator's display side.
- Decodes the four seven-segment buses back into operand, sum and carry nibbles, one digit per cycle through a single shared decoder.
- Checks operand A + operand B against the displayed {carry, sum} and keeps saturating pass/fail counters.
- Sits between the calculator's HEX outputs and on-board status logic or a bench scoreboard.

## Interface
- CNT_W, 8, width of PASS_CNT/FAIL_CNT (≥2)
- CLK  in  1  single clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- HEX0  in  7  operand A digit, active-low segments, bit6=g … bit0=a
- HEX1  in  7  operand B digit, same encoding
- HEX2  in  7  sum digit, same encoding
- HEX3  in  7  carry digit, same encoding; only 0 or 1 legal
- START  in  1  request one check; sampled only in IDLE
- CLR_CNT  in  1  synchronous clear of both counters
- BUSY  out  1  check in progress
- DONE  out  1  one-cycle pulse when results are updated
- VALUE_A, VALUE_B, SUM  out  4 each  decoded digits
- COUT  out  1  decoded carry digit
- ERR_MASK  out  4  bit i set = HEXi pattern illegal
- PATTERN_ERR  out  1  OR of ERR_MASK
- MATCH  out  1  VALUE_A+VALUE_B == {COUT,SUM} and no pattern error
- PASS_CNT, FAIL_CNT  out  CNT_W each  saturating result counters

## Operation
- Legal patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Any other 7-bit value is illegal: set ERR_MASK bit, decoded nibble 0.
- HEX3 is legal only as 0 or 1; any other pattern, including legal hex 2–F, sets ERR_MASK[3], COUT=0.
- FSM states:
  - IDLE: START=1 → snapshot HEX0..HEX3 into internal registers, digit index=0, go to SCAN.
  - SCAN: decode snapshot digit[index], store it, index++. After index 3, go to CHECK.
  - CHECK: compute the 5-bit sum VALUE_A+VALUE_B and compare with {COUT,SUM}. Update MATCH, PATTERN_ERR, ERR_MASK. Increment PASS_CNT if MATCH else FAIL_CNT. Pulse DONE, return to IDLE.
- The snapshot makes the check immune to HEX changes after START is accepted.
- Result outputs change only at the DONE edge and hold until the next DONE. Partial decodes stay in internal registers until then.
- Counters saturate at 2^CNT_W−1.
- CLR_CNT zeroes both counters. If it coincides with a CHECK increment, the clear wins.

## Timing
- Reset (async assert, any state): IDLE, BUSY=0, DONE=0, all result outputs 0, MATCH=0, counters 0. A check in progress is abandoned with no DONE.
- START accepted at edge t0 → BUSY=1 after t0; digits decoded at t1..t4 → CHECK; at t5 results, counter update and DONE=1, BUSY=0.
- Latency START-edge to DONE visible: 5 cycles. Throughput: a new START is accepted at t6 at the earliest, while DONE is high in that cycle.
- START while BUSY, or held high in CHECK, is ignored. It is not queued.
- START held continuously gives one check every 6 cycles.

## Test plan
- HEX0=0110000, HEX1=0100100, HEX2=0010010, HEX3=1000000, START → DONE exactly 5 cycles later. Result: A=3, B=2, SUM=5, COUT=0, MATCH=1, PASS_CNT=1.
- HEX0=HEX1=0001110 (F), HEX2=0000110 (E), HEX3=1111001 → MATCH=1, COUT=1, SUM=E.
  - Repeat with HEX2=1000000 → MATCH=0, FAIL_CNT=1, PATTERN_ERR=0.
- HEX2=1111111 → ERR_MASK=0100, PATTERN_ERR=1, MATCH=0, FAIL_CNT incremented.
  - Repeat with HEX3=0100100 (2) → ERR_MASK=1000.
- START, then change all HEX inputs at t1 and pulse START again at t2 → results reflect the t0 snapshot, exactly one DONE.
  - Assert RST_N=0 at t3 → no DONE, all outputs 0.
- CNT_W=2: five passing checks → PASS_CNT saturates at 3.
  - CLR_CNT asserted on a DONE cycle → both counters 0 afterward.
